// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin arbiter that shares one signed 32-bit
// comparator among NUM_REQ requesters. The result of the granted
// comparison is kept in a one-entry output buffer, tagged with the
// requester index, and drained with a valid/ready handshake.
module compare_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_lt,
    output logic                  rsp_eq
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_lt_q;
    logic               rsp_eq_q;

    logic               can_issue;
    logic               fire;
    logic               hi_found, lo_found;
    logic [NUM_REQ-1:0] hi_oh, lo_oh;
    logic [ID_W-1:0]    hi_idx, lo_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic signed [31:0] sel_a, sel_b;
    logic               cmp_lt, cmp_eq;

    // Shared signed magnitude comparator: returns {lt, eq}; eq implies !lt.
    function automatic logic [1:0] compare_32(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
        logic lt;
        logic eq;
        eq = (a == b);
        lt = (a < b);
        return {lt, eq};
    endfunction

    assign can_issue = (state_q == EMPTY) | rsp_ready;

    // Round-robin pick: lowest valid index above last_grant, else wrap to
    // the lowest valid index at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_oh    = '0;
        lo_oh    = '0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(last_grant_q)) begin
                    hi_found  = 1'b1;
                    hi_oh     = '0;
                    hi_oh[i]  = 1'b1;
                    hi_idx    = ID_W'(i);
                end else begin
                    lo_found  = 1'b1;
                    lo_oh     = '0;
                    lo_oh[i]  = 1'b1;
                    lo_idx    = ID_W'(i);
                end
            end
        end
    end

    // Grant is suppressed during reset and whenever the buffer cannot accept.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        if (can_issue && !reset) begin
            if (hi_found) begin
                grant_oh  = hi_oh;
                grant_idx = hi_idx;
            end else if (lo_found) begin
                grant_oh  = lo_oh;
                grant_idx = lo_idx;
            end
        end
    end

    assign req_ready = grant_oh;
    assign fire      = |grant_oh;

    // Operand mux driven by the one-hot grant, feeding the comparator.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
        {cmp_lt, cmp_eq} = compare_32(sel_a, sel_b);
    end

    // Buffer occupancy next state and round-robin pointer update.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            EMPTY: begin
                if (fire) state_d = FULL;
            end
            FULL: begin
                if (rsp_ready && !fire) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (fire) last_grant_d = grant_idx;
    end

    // Control registers: buffer state and last granted index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Result buffer: loaded on every grant, otherwise held stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_id_q <= '0;
            rsp_lt_q <= 1'b0;
            rsp_eq_q <= 1'b0;
        end else if (fire) begin
            rsp_id_q <= grant_idx;
            rsp_lt_q <= cmp_lt;
            rsp_eq_q <= cmp_eq;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_lt    = rsp_lt_q;
    assign rsp_eq    = rsp_eq_q;

endmodule
